// File: rtl/btn_cmd_pkg.sv
// btn_cmd_pkg: shared state encoding, default frame bytes and checksum helper
package btn_cmd_pkg;
  typedef enum logic [1:0] {IDLE, SEND_SOF, SEND_CMD, SEND_CHK} state_e;
  localparam logic [7:0] SOF_BYTE_DEF = 8'hAA;
  localparam logic [7:0] CMD_BASE_DEF = 8'h10;
  function automatic logic [7:0] frame_chk(input logic [7:0] sof, input logic [7:0] cmd);
    return sof ^ cmd;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small synchronous FIFO holding granted button indices
module cmd_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o = mem_q[rd_q];
  assign cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  // storage needs no reset; only entries below the count are ever read
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/btn_cmd_framer.sv
// btn_cmd_framer: turns debounced button presses into SOF/CMD/CHK UART frames
module btn_cmd_framer
  import btn_cmd_pkg::*;
#(
  parameter int NUM_BTN = 4,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] SOF_BYTE = SOF_BYTE_DEF,
  parameter logic [7:0] CMD_BASE = CMD_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overflow
);
  localparam int IW = NUM_BTN > 1 ? $clog2(NUM_BTN) : 1;
  state_e state_q, state_d;
  logic [NUM_BTN-1:0] pending_q, pending_d, grant;
  logic [IW-1:0] idx, fifo_idx;
  logic [7:0] cmd_q, cmd_d;
  logic overflow_q, drop, full, empty, pop, hs;
  cmd_fifo #(.W(IW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(|grant), .data_i(idx),
    .pop_i(pop), .data_o(fifo_idx), .full_o(full), .empty_o(empty)
  );
  // lowest-index pending press wins; nothing is granted while the FIFO is full
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = NUM_BTN-1; i >= 0; i--)
      if (pending_q[i]) begin
        grant = NUM_BTN'(1) << i;
        idx = IW'(i);
      end
    if (full) grant = '0;
  end
  assign pending_d = (pending_q & ~grant) | btn_pulse;
  assign drop = |(btn_pulse & pending_q & ~grant);
  // frame sequencing; the CHK handshake chains straight into the next frame
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    hs = tx_valid & tx_ready;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        state_d = SEND_SOF;
      end
      SEND_SOF: if (hs) state_d = SEND_CMD;
      SEND_CMD: if (hs) state_d = SEND_CHK;
      default: if (hs) begin
        pop = ~empty;
        state_d = empty ? IDLE : SEND_SOF;
      end
    endcase
  end
  assign cmd_d = pop ? CMD_BASE + 8'(fifo_idx) : cmd_q;
  // capture, overflow flag, FSM state and latched command byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending_q <= '0;
      overflow_q <= 1'b0;
      state_q <= IDLE;
      cmd_q <= '0;
    end else begin
      pending_q <= pending_d;
      overflow_q <= drop;
      state_q <= state_d;
      cmd_q <= cmd_d;
    end
  assign tx_valid = state_q != IDLE;
  assign tx_data = state_q == SEND_SOF ? SOF_BYTE :
                   state_q == SEND_CMD ? cmd_q :
                   state_q == SEND_CHK ? frame_chk(SOF_BYTE, cmd_q) : 8'h00;
  assign busy = (pending_q != '0) | ~empty | tx_valid;
  assign overflow = overflow_q;
endmodule
